gps_multi_ch_ctrl: RTL and testbench
====================================

// Module: gps_multi_ch_ctrl
// PURPOSE
//  Round-robin capture/encrypt sequencer for NUM_CH GPS satellite channels.
//  Per round it drives one shared C/A + P code generator pair, one enabled channel at a time.
//  Per channel it captures CA_LEN C/A chips and P_LEN P chips, then hands the P block to an
//  external encrypt engine over a start/valid handshake. Results are banked per channel.
//  Sits between the SoC register interface and the code generators / AES engine.
// PARAMETERS
//  NUM_CH   4    satellite channels per round (1..16)
//  CA_LEN   13   C/A chips captured per channel (1..P_LEN)
//  P_LEN    128  P chips captured per channel; also the width of the encrypt block
//  ENC_TMO  64   cycles to wait for enc_valid before declaring a channel timeout
//  CH_W     $clog2(NUM_CH) (min 1), derived: channel index width
// PORTS
//  clk             in  1             single clock, rising edge
//  async_rst_n_in  in  1             asynchronous, active-low reset
//  start           in  1             level; round begins on its 0->1 edge
//  abort           in  1             synchronous; ends the round at once
//  ch_mask         in  NUM_CH        channel enables, snapshotted at round start
//  sv_num_tbl      in  6*NUM_CH      PRN per channel, ch i = [6i+5:6i], snapshotted at round start
//  busy            out 1             round in progress
//  done            out 1             1-cycle pulse at end of round (not raised on abort)
//  cur_ch          out CH_W          channel being processed
//  gen_sv_num      out 6             PRN driven to the generators
//  gen_prn_changed out 1             1-cycle pulse: generators reload for the new PRN
//  gen_en          out 1             generator advance enable
//  ca_bit_in       in  1             C/A chip, valid in the cycle gen_en=1
//  p_bit_in        in  1             P chip, valid in the cycle gen_en=1
//  enc_start       out 1             1-cycle pulse to the encrypt engine
//  enc_state       out P_LEN         captured P block, MSB = first chip; held while ENC
//  enc_out         in  P_LEN         encrypt result
//  enc_valid       in  1             enc_out valid (sampled only while in ENC)
//  ca_code         out CA_LEN*NUM_CH captured C/A per channel
//  l_code          out P_LEN*NUM_CH  encrypted block per channel
//  l_valid         out NUM_CH        sticky: channel result valid this round
//  enc_err         out NUM_CH        sticky: channel hit the encrypt timeout this round
// BEHAVIOUR
//  Reset, async: every output and register is 0 and the FSM is in IDLE. Reset mid-round drops the round.
//  Start edge: detected with a registered copy of start. An edge while busy is ignored.
//  FSM: IDLE -> SCAN -> LOAD -> RUN -> ENC -> STORE -> SCAN ... -> FIN -> IDLE.
//  IDLE, on a start edge:
//   - snapshot ch_mask and sv_num_tbl
//   - clear l_valid and enc_err
//   - busy=1, search pointer=0, go to SCAN
//  SCAN, one cycle:
//   - pick the lowest enabled channel >= the pointer
//   - found: set cur_ch and go to LOAD; none found: go to FIN
//   - mask==0 gives done 2 cycles after the start edge
//  LOAD, one cycle: gen_prn_changed=1, gen_sv_num=snapshot[cur_ch], clear the shift registers and the chip counter.
//  RUN: gen_en=1 for exactly P_LEN cycles.
//   - P chips shift in on every one of those cycles
//   - C/A chips shift in on the first CA_LEN cycles only
//   - the counter is 8+ bits sized for P_LEN and does not wrap
//   - leave to ENC on the cycle after the last chip
//  ENC:
//   - enc_start=1 on the entry cycle only
//   - enc_valid is sampled from the following cycle on
//   - enc_valid=1: go to STORE
//   - ENC_TMO sampled cycles without enc_valid: set enc_err[cur_ch], skip the store, go to SCAN
//  STORE, one cycle: write l_code slot and ca_code slot for cur_ch, set l_valid[cur_ch], pointer=cur_ch+1, go to SCAN.
//  FIN, one cycle: done=1, busy=0, go to IDLE.
//  Per-channel latency with no timeout: 1 (SCAN) + 1 (LOAD) + P_LEN + (1 + k) (ENC) + 1 (STORE); k = enc_valid delay.
//  abort, any non-IDLE state: to IDLE next cycle. gen_en=0, busy=0, no done; completed slots and l_valid kept.
//  abort and a start edge in the same IDLE cycle: abort wins.
//  ca_code/l_code slots of unvisited or timed-out channels keep their prior contents.
//  gen_sv_num holds its last value outside LOAD/RUN.
// STRUCTURE
//  Package gps_pkg:
//   - FSM state enum
//   - PRN_W=6
//   - localparams for CA_LEN/P_LEN defaults
//  Sub-module gps_code_capture (CA_LEN, P_LEN): clear/shift C/A and P registers plus chip counter, last-chip flag.
//  Top holds the FSM, snapshot registers, priority channel search, timeout counter and result banks.
// TESTING
//  T1: NUM_CH=4, mask=4'b1111, PRNs 1..4, model generators, enc_valid 12 cycles after enc_start
//      -> 4 LOAD pulses with gen_sv_num 1,2,3,4; l_valid=4'hF; done once; ca_code/l_code match the model.
//  T2: mask=4'b1010 -> only ch1, ch3 visited; l_valid=4'b1010; gen_en high for exactly 2*128 cycles.
//  T3: mask=0 -> done 2 cycles after the start edge; no gen_en, no enc_start.
//  T4: ch2 never gets enc_valid -> enc_err=4'b0100 after 64 ENC cycles, l_valid=4'b1011, round completes.
//  T5: abort in RUN of ch1 -> busy=0 next cycle, no done, l_valid=4'b0001.
//      A start edge while busy produces no extra round.
//  T6: async_rst_n_in low mid-ENC, not clock-aligned -> all outputs 0 immediately.
//      A fresh start after release runs a clean round.

Source files
------------

// File: rtl/gps_pkg.sv
// Shared types and constants for the GPS multi-channel capture/encrypt sequencer.
package gps_pkg;

  localparam int unsigned PRN_W      = 6;
  localparam int unsigned CA_LEN_DEF = 13;
  localparam int unsigned P_LEN_DEF  = 128;

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StLoad,
    StRun,
    StEnc,
    StStore,
    StFin
  } state_e;

  // Chip counter is at least 8 bits and wide enough to hold P_LEN without wrapping.
  function automatic int unsigned cnt_width(input int unsigned len);
    int unsigned w;
    w = $clog2(len + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/gps_multi_ch_ctrl_if.sv
// Bundle of the sequencer's control, generator, encrypt and result signals.
interface gps_multi_ch_ctrl_if
  import gps_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CA_LEN = CA_LEN_DEF,
  parameter int unsigned P_LEN  = P_LEN_DEF
) ();

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Register side
  logic                       start;
  logic                       abort;
  logic [NUM_CH-1:0]          ch_mask;
  logic [PRN_W*NUM_CH-1:0]    sv_num_tbl;
  logic                       busy;
  logic                       done;
  logic [CH_W-1:0]            cur_ch;
  // Code generators
  logic [PRN_W-1:0]           gen_sv_num;
  logic                       gen_prn_changed;
  logic                       gen_en;
  logic                       ca_bit_in;
  logic                       p_bit_in;
  // Encrypt engine
  logic                       enc_start;
  logic [P_LEN-1:0]           enc_state;
  logic [P_LEN-1:0]           enc_out;
  logic                       enc_valid;
  // Result banks
  logic [CA_LEN*NUM_CH-1:0]   ca_code;
  logic [P_LEN*NUM_CH-1:0]    l_code;
  logic [NUM_CH-1:0]          l_valid;
  logic [NUM_CH-1:0]          enc_err;

  modport master (
    output start, abort, ch_mask, sv_num_tbl, ca_bit_in, p_bit_in, enc_out, enc_valid,
    input  busy, done, cur_ch, gen_sv_num, gen_prn_changed, gen_en, enc_start, enc_state,
    input  ca_code, l_code, l_valid, enc_err
  );

  modport slave (
    input  start, abort, ch_mask, sv_num_tbl, ca_bit_in, p_bit_in, enc_out, enc_valid,
    output busy, done, cur_ch, gen_sv_num, gen_prn_changed, gen_en, enc_start, enc_state,
    output ca_code, l_code, l_valid, enc_err
  );

endinterface

// File: rtl/gps_code_capture.sv
// Captures C/A and P chips from the shared generators; MSB holds the first chip.
module gps_code_capture
  import gps_pkg::*;
#(
  parameter int unsigned CA_LEN = CA_LEN_DEF,
  parameter int unsigned P_LEN  = P_LEN_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              shift_i,
  input  logic              ca_bit_i,
  input  logic              p_bit_i,
  output logic [CA_LEN-1:0] ca_o,
  output logic [P_LEN-1:0]  p_o,
  output logic              last_o
);

  localparam int unsigned CntW = cnt_width(P_LEN);

  logic [CA_LEN-1:0] ca_q, ca_d;
  logic [P_LEN-1:0]  p_q, p_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // Next-state: clear on reload, otherwise shift; C/A stops after CA_LEN chips.
  always_comb begin
    ca_d  = ca_q;
    p_d   = p_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      ca_d  = '0;
      p_d   = '0;
      cnt_d = '0;
    end else if (shift_i) begin
      p_d = (p_q << 1) | P_LEN'(p_bit_i);
      if (cnt_q < CntW'(CA_LEN)) begin
        ca_d = (ca_q << 1) | CA_LEN'(ca_bit_i);
      end
      // Saturate rather than wrap.
      if (cnt_q != CntW'(P_LEN)) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Capture registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ca_q  <= '0;
      p_q   <= '0;
      cnt_q <= '0;
    end else begin
      ca_q  <= ca_d;
      p_q   <= p_d;
      cnt_q <= cnt_d;
    end
  end

  assign ca_o   = ca_q;
  assign p_o    = p_q;
  assign last_o = shift_i && (cnt_q == CntW'(P_LEN - 1));

endmodule

// File: rtl/gps_multi_ch_ctrl.sv
// Round-robin capture/encrypt sequencer over NUM_CH satellite channels.
module gps_multi_ch_ctrl
  import gps_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CA_LEN  = CA_LEN_DEF,
  parameter int unsigned P_LEN   = P_LEN_DEF,
  parameter int unsigned ENC_TMO = 64
) (
  input logic                clk,
  input logic                async_rst_n_in,
  gps_multi_ch_ctrl_if.slave bus
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // Search pointer must reach NUM_CH to mean "past the last channel".
  localparam int unsigned PTR_W = CH_W + 1;
  localparam int unsigned TMO_W = $clog2(ENC_TMO + 1);

  state_e                   state_q, state_d;
  logic                     start_q, start_d;
  logic [NUM_CH-1:0]        mask_q, mask_d;
  logic [PRN_W*NUM_CH-1:0]  sv_q, sv_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [CH_W-1:0]          cur_ch_q, cur_ch_d;
  logic [PRN_W-1:0]         gen_sv_q, gen_sv_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic [P_LEN-1:0]         enc_res_q, enc_res_d;
  logic [CA_LEN*NUM_CH-1:0] ca_bank_q, ca_bank_d;
  logic [P_LEN*NUM_CH-1:0]  l_bank_q, l_bank_d;
  logic [NUM_CH-1:0]        l_valid_q, l_valid_d;
  logic [NUM_CH-1:0]        enc_err_q, enc_err_d;

  logic              start_edge;
  logic              found;
  logic [CH_W-1:0]   sel_ch;
  logic              cap_clr;
  logic              run_en;
  logic [CA_LEN-1:0] cap_ca;
  logic [P_LEN-1:0]  cap_p;
  logic              cap_last;

  assign start_edge = bus.start && !start_q;
  assign run_en     = (state_q == StRun);

  gps_code_capture #(
    .CA_LEN (CA_LEN),
    .P_LEN  (P_LEN)
  ) u_capture (
    .clk_i    (clk),
    .rst_ni   (async_rst_n_in),
    .clr_i    (cap_clr),
    .shift_i  (run_en),
    .ca_bit_i (bus.ca_bit_in),
    .p_bit_i  (bus.p_bit_in),
    .ca_o     (cap_ca),
    .p_o      (cap_p),
    .last_o   (cap_last)
  );

  // Priority search: lowest enabled channel at or above the pointer.
  always_comb begin
    found  = 1'b0;
    sel_ch = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (mask_q[i] && (i >= int'(ptr_q))) begin
        found  = 1'b1;
        sel_ch = CH_W'(i);
      end
    end
  end

  // FSM next-state and register updates.
  always_comb begin
    state_d   = state_q;
    start_d   = bus.start;
    mask_d    = mask_q;
    sv_d      = sv_q;
    ptr_d     = ptr_q;
    cur_ch_d  = cur_ch_q;
    gen_sv_d  = gen_sv_q;
    tmo_d     = tmo_q;
    enc_res_d = enc_res_q;
    ca_bank_d = ca_bank_q;
    l_bank_d  = l_bank_q;
    l_valid_d = l_valid_q;
    enc_err_d = enc_err_q;
    cap_clr   = 1'b0;

    if (bus.abort && (state_q != StIdle)) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          // abort suppresses a coincident start edge
          if (start_edge && !bus.abort) begin
            mask_d    = bus.ch_mask;
            sv_d      = bus.sv_num_tbl;
            l_valid_d = '0;
            enc_err_d = '0;
            ptr_d     = '0;
            state_d   = StScan;
          end
        end
        StScan: begin
          if (found) begin
            cur_ch_d = sel_ch;
            // Loaded here so the PRN is already stable during the LOAD pulse.
            gen_sv_d = sv_q[int'(sel_ch) * PRN_W +: PRN_W];
            state_d  = StLoad;
          end else begin
            state_d = StFin;
          end
        end
        StLoad: begin
          cap_clr = 1'b1;
          tmo_d   = '0;
          state_d = StRun;
        end
        StRun: begin
          if (cap_last) begin
            state_d = StEnc;
          end
        end
        StEnc: begin
          if (tmo_q == '0) begin
            tmo_d = TMO_W'(1);
          end else if (bus.enc_valid) begin
            enc_res_d = bus.enc_out;
            state_d   = StStore;
          end else if (tmo_q == TMO_W'(ENC_TMO)) begin
            enc_err_d[cur_ch_q] = 1'b1;
            ptr_d               = PTR_W'(cur_ch_q) + PTR_W'(1);
            state_d             = StScan;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        StStore: begin
          ca_bank_d[int'(cur_ch_q) * CA_LEN +: CA_LEN] = cap_ca;
          l_bank_d[int'(cur_ch_q) * P_LEN +: P_LEN]    = enc_res_q;
          l_valid_d[cur_ch_q]                          = 1'b1;
          ptr_d                                        = PTR_W'(cur_ch_q) + PTR_W'(1);
          state_d                                      = StScan;
        end
        StFin: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State and bank registers.
  always_ff @(posedge clk or negedge async_rst_n_in) begin
    if (!async_rst_n_in) begin
      state_q   <= StIdle;
      start_q   <= 1'b0;
      mask_q    <= '0;
      sv_q      <= '0;
      ptr_q     <= '0;
      cur_ch_q  <= '0;
      gen_sv_q  <= '0;
      tmo_q     <= '0;
      enc_res_q <= '0;
      ca_bank_q <= '0;
      l_bank_q  <= '0;
      l_valid_q <= '0;
      enc_err_q <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      mask_q    <= mask_d;
      sv_q      <= sv_d;
      ptr_q     <= ptr_d;
      cur_ch_q  <= cur_ch_d;
      gen_sv_q  <= gen_sv_d;
      tmo_q     <= tmo_d;
      enc_res_q <= enc_res_d;
      ca_bank_q <= ca_bank_d;
      l_bank_q  <= l_bank_d;
      l_valid_q <= l_valid_d;
      enc_err_q <= enc_err_d;
    end
  end

  assign bus.busy            = (state_q != StIdle) && (state_q != StFin);
  assign bus.done            = (state_q == StFin);
  assign bus.cur_ch          = cur_ch_q;
  assign bus.gen_sv_num      = gen_sv_q;
  assign bus.gen_prn_changed = (state_q == StLoad);
  assign bus.gen_en          = run_en;
  assign bus.enc_start       = (state_q == StEnc) && (tmo_q == '0);
  assign bus.enc_state       = cap_p;
  assign bus.ca_code         = ca_bank_q;
  assign bus.l_code          = l_bank_q;
  assign bus.l_valid         = l_valid_q;
  assign bus.enc_err         = enc_err_q;

endmodule

// File: tb/tb_gps_multi_ch_ctrl.sv
// Scoreboard bench for gps_multi_ch_ctrl: expectations are queued at stimulus time and
// popped by a monitor on LOAD, enc_start and done events.
module tb_gps_multi_ch_ctrl;

  localparam int NCH  = 4;
  localparam int CAL  = 13;
  localparam int PL   = 128;
  localparam logic [127:0] KEY = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

  typedef struct {
    logic [3:0]   lv;
    logic [3:0]   ee;
    logic [51:0]  ca;
    logic [511:0] lc;
  } done_t;

  logic clk;
  logic rst_n;

  gps_multi_ch_ctrl_if #(.NUM_CH(NCH), .CA_LEN(CAL), .P_LEN(PL)) bus ();

  gps_multi_ch_ctrl #(
    .NUM_CH  (NCH),
    .CA_LEN  (CAL),
    .P_LEN   (PL),
    .ENC_TMO (64)
  ) dut (
    .clk            (clk),
    .async_rst_n_in (rst_n),
    .bus            (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int gen_en_cnt = 0;
  int enc_cnt = 0;
  int done_cnt = 0;
  int noresp = -1;
  int t_enc = 0;
  bit gap_armed = 1'b0;

  logic [5:0]   q_load[$];
  logic [127:0] q_enc[$];
  done_t        q_done[$];
  logic [51:0]  eca = '0;
  logic [511:0] elc = '0;

  // Generator and encrypt-engine reference models
  function automatic logic ca_fn(input int prn, input int j);
    logic [31:0] h;
    h = (32'(prn) * 32'h9E37_79B1) ^ (32'(j + 1) * 32'h85EB_CA6B);
    return h[11] ^ h[23] ^ h[30];
  endfunction

  function automatic logic p_fn(input int prn, input int j);
    logic [31:0] h;
    h = (32'(prn + 7) * 32'hC2B2_AE35) ^ (32'(j + 3) * 32'h27D4_EB2F);
    return h[9] ^ h[17] ^ h[28];
  endfunction

  function automatic logic [12:0] ca_blk(input int prn);
    logic [12:0] b;
    for (int j = 0; j < CAL; j++) b[CAL-1-j] = ca_fn(prn, j);
    return b;
  endfunction

  function automatic logic [127:0] p_blk(input int prn);
    logic [127:0] b;
    for (int j = 0; j < PL; j++) b[PL-1-j] = p_fn(prn, j);
    return b;
  endfunction

  function automatic logic [127:0] enc_f(input logic [127:0] b);
    return {b[63:0], b[127:64]} ^ KEY;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name, input logic [511:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got event with %0h want no event", name, act);
  endtask

  // kind 0: done, 1: LOAD of channel ch, 2: enc_start of channel ch
  task automatic wait_ev(input int kind, input int ch, input int max, input string name);
    bit hit = 1'b0;
    for (int n = 0; n < max && !hit; n++) begin
      @(negedge clk);
      case (kind)
        0:       hit = bus.done;
        1:       hit = bus.gen_prn_changed && (int'(bus.cur_ch) == ch);
        default: hit = bus.enc_start && (int'(bus.cur_ch) == ch);
      endcase
    end
    if (!hit) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got timeout after %0d cycles want event", name, max);
    end
  endtask

  // Generator model: chip index restarts on each reload.
  initial begin
    int idx = 0;
    bus.ca_bit_in = 1'b0;
    bus.p_bit_in  = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.gen_prn_changed) begin
        idx = 0;
      end else if (bus.gen_en) begin
        bus.ca_bit_in = ca_fn(int'(bus.gen_sv_num), idx);
        bus.p_bit_in  = p_fn(int'(bus.gen_sv_num), idx);
        idx++;
      end
    end
  end

  // Encrypt engine model: answers 12 cycles after enc_start except for channel noresp.
  initial begin
    logic [127:0] blk;
    bus.enc_valid = 1'b0;
    bus.enc_out   = '0;
    forever begin
      @(negedge clk);
      if (bus.enc_start && (int'(bus.cur_ch) != noresp)) begin
        blk = bus.enc_state;
        repeat (12) @(negedge clk);
        bus.enc_out   = enc_f(blk);
        bus.enc_valid = 1'b1;
        @(negedge clk);
        bus.enc_valid = 1'b0;
      end
    end
  end

  // Monitor: pop and compare on every DUT event.
  initial begin
    done_t d;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.gen_en) gen_en_cnt++;
      if (bus.gen_prn_changed) begin
        if (gap_armed) begin
          check("tmo_gap", 512'(cyc - t_enc), 512'(66));
          gap_armed = 1'b0;
        end
        if (q_load.size() == 0) fail_event("unexpected_load", 512'(bus.gen_sv_num));
        else check("load_prn", 512'(bus.gen_sv_num), 512'(q_load.pop_front()));
      end
      if (bus.enc_start) begin
        enc_cnt++;
        if (noresp >= 0 && int'(bus.cur_ch) == noresp) begin
          t_enc     = cyc;
          gap_armed = 1'b1;
        end
        if (q_enc.size() == 0) fail_event("unexpected_enc_start", 512'(bus.enc_state));
        else check("enc_state", 512'(bus.enc_state), 512'(q_enc.pop_front()));
      end
      if (bus.done) begin
        done_cnt++;
        if (q_done.size() == 0) begin
          fail_event("unexpected_done", 512'(bus.l_valid));
        end else begin
          d = q_done.pop_front();
          check("done_l_valid", 512'(bus.l_valid), 512'(d.lv));
          check("done_enc_err", 512'(bus.enc_err), 512'(d.ee));
          check("done_ca_code", 512'(bus.ca_code), 512'(d.ca));
          check("done_l_code", bus.l_code, d.lc);
        end
      end
    end
  end

  // Queue a full round's expectations, run it, and wait for done.
  task automatic run_round(input logic [3:0] mask, input logic [23:0] tbl, input int exp_gen);
    done_t d;
    int    g0;
    logic [5:0] prn;
    d.lv = '0;
    d.ee = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (mask[ch]) begin
        prn = tbl[6*ch +: 6];
        q_load.push_back(prn);
        q_enc.push_back(p_blk(int'(prn)));
        if (ch == noresp) begin
          d.ee[ch] = 1'b1;
        end else begin
          eca[ch*CAL +: CAL] = ca_blk(int'(prn));
          elc[ch*PL +: PL]   = enc_f(p_blk(int'(prn)));
          d.lv[ch]           = 1'b1;
        end
      end
    end
    d.ca = eca;
    d.lc = elc;
    q_done.push_back(d);
    g0 = gen_en_cnt;
    @(negedge clk);
    bus.ch_mask    = mask;
    bus.sv_num_tbl = tbl;
    bus.start      = 1'b1;
    wait_ev(0, 0, 3000, "round_done");
    @(negedge clk);
    bus.start = 1'b0;
    check("gen_en_cycles", 512'(gen_en_cnt - g0), 512'(exp_gen));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    done_t d;
    int    g0;
    int    e0;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.ch_mask    = '0;
    bus.sv_num_tbl = '0;

    // Reset state
    #13;
    check("rst_ctrl", 512'({bus.busy, bus.done, bus.gen_en, bus.gen_prn_changed, bus.enc_start}),
          512'(0));
    check("rst_cur_ch", 512'(bus.cur_ch), 512'(0));
    check("rst_results", 512'({bus.l_valid, bus.enc_err, bus.ca_code}), 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // T1: all channels
    run_round(4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, 4 * PL);
    // T2: channels 1 and 3
    run_round(4'b1010, {6'd8, 6'd7, 6'd6, 6'd5}, 2 * PL);

    // T3: empty mask, done two edges after start
    d.lv = '0;
    d.ee = '0;
    d.ca = eca;
    d.lc = elc;
    q_done.push_back(d);
    g0 = gen_en_cnt;
    e0 = enc_cnt;
    @(negedge clk);
    bus.ch_mask = '0;
    bus.start   = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mask0_done_latency", 512'(bus.done), 512'(1));
    @(negedge clk);
    bus.start = 1'b0;
    check("mask0_gen_en", 512'(gen_en_cnt - g0), 512'(0));
    check("mask0_enc_start", 512'(enc_cnt - e0), 512'(0));

    // T4: channel 2 never answers
    noresp = 2;
    run_round(4'b1111, {6'd24, 6'd23, 6'd22, 6'd21}, 4 * PL);
    noresp = -1;

    // T5: abort during ch1 RUN, with a start edge while busy
    q_load.push_back(6'd9);
    q_load.push_back(6'd10);
    q_enc.push_back(p_blk(9));
    @(negedge clk);
    bus.ch_mask    = 4'b1111;
    bus.sv_num_tbl = {6'd12, 6'd11, 6'd10, 6'd9};
    bus.start      = 1'b1;
    wait_ev(1, 0, 50, "t5_load_ch0");
    repeat (5) @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    wait_ev(1, 1, 400, "t5_load_ch1");
    repeat (20) @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 512'(bus.busy), 512'(0));
    check("abort_gen_en", 512'(bus.gen_en), 512'(0));
    @(negedge clk);
    bus.abort = 1'b0;
    eca[0 +: CAL] = ca_blk(9);
    elc[0 +: PL]  = enc_f(p_blk(9));
    check("abort_l_valid", 512'(bus.l_valid), 512'(4'b0001));
    check("abort_ca_code", 512'(bus.ca_code), 512'(eca));
    check("abort_l_code", bus.l_code, elc);
    repeat (20) @(negedge clk);
    check("no_rerun_after_abort", 512'(bus.busy), 512'(0));
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_beats_start", 512'(bus.busy), 512'(0));
    bus.start = 1'b0;

    // T6: asynchronous reset mid-ENC of ch2
    q_load.push_back(6'd13);
    q_load.push_back(6'd14);
    q_load.push_back(6'd15);
    q_enc.push_back(p_blk(13));
    q_enc.push_back(p_blk(14));
    q_enc.push_back(p_blk(15));
    @(negedge clk);
    bus.sv_num_tbl = {6'd16, 6'd15, 6'd14, 6'd13};
    bus.start      = 1'b1;
    wait_ev(2, 2, 1000, "t6_enc_ch2");
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ctrl", 512'({bus.busy, bus.done, bus.gen_en, bus.gen_prn_changed, bus.enc_start}),
          512'(0));
    check("arst_cur_ch_sv", 512'({bus.cur_ch, bus.gen_sv_num}), 512'(0));
    check("arst_enc_state", 512'(bus.enc_state), 512'(0));
    check("arst_flags", 512'({bus.l_valid, bus.enc_err}), 512'(0));
    check("arst_ca_code", 512'(bus.ca_code), 512'(0));
    check("arst_l_code", bus.l_code, 512'(0));
    eca       = '0;
    elc       = '0;
    bus.start = 1'b0;
    #4;
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    run_round(4'b1111, {6'd20, 6'd19, 6'd18, 6'd17}, 4 * PL);

    repeat (5) @(negedge clk);
    check("queues_drained", 512'(q_load.size() + q_enc.size() + q_done.size()), 512'(0));
    check("done_pulses", 512'(done_cnt), 512'(5));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
